// File: rtl/pipeline_stage_buffer.sv
// pipeline_stage_buffer: valid/ready inter-stage register with a 2-entry skid
// buffer, registered in_ready and a synchronous flush that turns in-flight entries
// into bubbles.
// Optional statistics counters are enabled by defining PIPELINE_STAGE_STATS_EN.
module pipeline_stage_buffer #(
   parameter int unsigned CTRL_W     = 4,
   parameter int unsigned DATA_W     = 101,
   parameter bit          RESET_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       bubble_cycles
);

   // Encoding equals the entry count, so occupancy is read straight from the state.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
   logic [DATA_W-1:0]   main_data_q, skid_data_q;
   logic [DATA_W-1:0]   main_data_d, skid_data_d;
   logic                main_valid;
   logic                in_fire, out_fire;
   logic                load_main_in, load_skid_in, load_main_skid;

   assign main_valid = (state_q != S_EMPTY);
   assign in_fire    = in_valid & in_ready_q;
   assign out_fire   = main_valid & out_ready;

   // Next-state and load selection; flush overrides every transfer.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_main_skid = 1'b0;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  state_d      = S_ONE;
                  load_main_in = 1'b1;
               end
            end
            S_ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  state_d      = S_TWO;
                  load_skid_in = 1'b1;
               end else if (out_fire) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               if (out_fire) begin
                  state_d        = S_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
      in_ready_d = (state_d != S_TWO);
   end

   // Data next values; data is held (not cleared) on flush.
   always_comb begin
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      if (load_main_in)   main_data_d = in_data;
      if (load_main_skid) main_data_d = skid_data_q;
      if (load_skid_in)   skid_data_d = in_data;
   end

   // State, in_ready and control bundles; control is zeroed on reset or flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         main_ctrl_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         if (flush) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
         end else begin
            if (load_main_in)   main_ctrl_q <= in_ctrl;
            if (load_main_skid) main_ctrl_q <= skid_ctrl_q;
            if (load_skid_in)   skid_ctrl_q <= in_ctrl;
         end
      end
   end

   // Data registers, with or without reset depending on RESET_DATA.
   if (RESET_DATA) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            main_data_q <= '0;
            skid_data_q <= '0;
         end else begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
         end
      end
   end else begin : g_data_norst
      always_ff @(posedge clk) begin
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl_q : CTRL_W'(0);
   assign out_data  = main_data_q;
   assign occupancy = 2'(state_q);

`ifdef PIPELINE_STAGE_STATS_EN
   logic [31:0] stall_q, bubble_q;

   // Saturating stall/bubble counters; cleared by reset only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (main_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
         if (!main_valid && (bubble_q != 32'hFFFF_FFFF))
            bubble_q <= bubble_q + 32'd1;
      end
   end

   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;
`else
   assign stall_cycles  = 32'h0;
   assign bubble_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Testbench for pipeline_stage_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the stage.
module tb_pipeline_stage_buffer;
   localparam int unsigned CTRL_W = 4;
   localparam int unsigned DATA_W = 101;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [31:0]       stall_cycles;
   logic [31:0]       bubble_cycles;

   pipeline_stage_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RESET_DATA(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t      mq[$];
   int unsigned m_stall, m_bubble;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef PIPELINE_STAGE_STATS_EN
      return 32'(v);
`else
      return 32'h0 & 32'(v);
`endif
   endfunction

   // Compare every output against the model queue.
   task automatic check_all();
      chk("occupancy", 128'(occupancy), 128'(mq.size()));
      chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
      chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
      chk("out_ctrl", 128'(out_ctrl), (mq.size() > 0) ? 128'(mq[0].ctrl) : 128'(0));
      if (mq.size() > 0) chk("out_data", 128'(out_data), 128'(mq[0].data));
      chk("stall_cycles", 128'(stall_cycles), 128'(exp_cnt(m_stall)));
      chk("bubble_cycles", 128'(bubble_cycles), 128'(exp_cnt(m_bubble)));
   endtask

   // One clock cycle: drive inputs, advance model, check after the edge.
   task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
      bit     ifire, ofire;
      entry_t e;
      in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
      ifire = v && (mq.size() < 2);
      ofire = (mq.size() > 0) && ordy;
      if (mq.size() > 0 && !ordy) m_stall++;
      if (mq.size() == 0) m_bubble++;
      @(posedge clk);
      if (ofire) void'(mq.pop_front());
      if (fl) mq.delete();
      else if (ifire) begin
         e.ctrl = c; e.data = d;
         mq.push_back(e);
      end
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse placed mid-cycle; checks take effect before any edge.
   task automatic mid_reset();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      mq.delete(); m_stall = 0; m_bubble = 0;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
      chk("rst_occupancy", 128'(occupancy), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_stall", 128'(stall_cycles), 128'(0));
      chk("rst_bubble", 128'(bubble_cycles), 128'(0));
      #3;
      rst = 1'b0;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      return DATA_W'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;
      m_stall = 0; m_bubble = 0;
      #12;
      rst = 1'b0;
      check_all();
      chk("init_out_data", 128'(out_data), 128'(0));

      // Reset mid-transfer with an entry held under back-pressure.
      step(1'b1, 4'hA, DATA_W'(1), 1'b0, 1'b0);
      chk("held_ctrl", 128'(out_ctrl), 128'(4'hA));
      mid_reset();

      // Streaming 1..8 with out_ready high.
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 4'h1, DATA_W'(k), 1'b1, 1'b0);
         chk("stream_data", 128'(out_data), 128'(k));
         chk("stream_occ", 128'(occupancy), 128'(1));
      end
      step(1'b0, 4'h0, DATA_W'(0), 1'b1, 1'b0);

      // Back-pressure: A then B, then release.
      step(1'b1, 4'h1, DATA_W'(8'h11), 1'b0, 1'b0);
      step(1'b1, 4'h2, DATA_W'(8'h22), 1'b0, 1'b0);
      chk("bp_occ", 128'(occupancy), 128'(2));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_head_a", 128'(out_data), 128'(8'h11));
      step(1'b0, 4'h0, DATA_W'(0), 1'b1, 1'b0);
      chk("bp_head_b", 128'(out_data), 128'(8'h22));
      chk("bp_ready_back", 128'(in_ready), 128'(1));

      // Simultaneous push/pop while holding one entry.
      step(1'b1, 4'h3, DATA_W'(8'h55), 1'b1, 1'b0);
      chk("pushpop_occ", 128'(occupancy), 128'(1));
      chk("pushpop_data", 128'(out_data), 128'(8'h55));
      chk("pushpop_ctrl", 128'(out_ctrl), 128'(4'h3));

      // Flush while full with a push attempt in the flush cycle.
      step(1'b1, 4'h4, DATA_W'(8'h66), 1'b0, 1'b0);
      chk("pre_flush_occ", 128'(occupancy), 128'(2));
      step(1'b1, 4'hF, DATA_W'(8'h77), 1'b0, 1'b1);
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_ctrl", 128'(out_ctrl), 128'(0));
      chk("flush_occ", 128'(occupancy), 128'(0));
      chk("flush_ready", 128'(in_ready), 128'(1));
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 4'h0, DATA_W'(0), 1'b1, 1'b0);
         chk("flush_no_emit", 128'(out_valid), 128'(0));
      end

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         step(1'b1 & ($urandom_range(0, 3) != 0), 4'($urandom), rnd_data(),
              1'b1 & ($urandom_range(0, 2) != 0), 1'b1 & ($urandom_range(0, 30) == 0));
      end

      // Stats: one bubble while pushing, 5 stalls, pop, 2 more bubbles.
      mid_reset();
      step(1'b1, 4'h5, DATA_W'(7), 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 4'h0, DATA_W'(0), 1'b0, 1'b0);
      step(1'b0, 4'h0, DATA_W'(0), 1'b1, 1'b0);
      step(1'b0, 4'h0, DATA_W'(0), 1'b1, 1'b0);
      step(1'b0, 4'h0, DATA_W'(0), 1'b1, 1'b0);
`ifdef PIPELINE_STAGE_STATS_EN
      chk("stats_stall", 128'(stall_cycles), 128'(32'd5));
      chk("stats_bubble", 128'(bubble_cycles), 128'(32'd3));
`else
      chk("stats_stall_off", 128'(stall_cycles), 128'(32'd0));
      chk("stats_bubble_off", 128'(bubble_cycles), 128'(32'd0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_stage_buffer.md
Name: pipeline_stage_buffer

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (for example, memory-to-writeback).
- Carries a CTRL_W-bit control bundle and a DATA_W-bit datapath bundle between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so `in_ready` is fully registered and back-pressure does not form a combinational path through the stage.
- Adds a synchronous flush that turns in-flight entries into bubbles; the fixed registers only support stall.

Parameters:
- CTRL_W, 4: width of the control bundle (for example RegWrite plus ResultSrc). Entries are cleared to a bubble on reset or flush.
- DATA_W, 101: width of the datapath bundle (for example ALUResult, ReadData, Rd, PCPlus4 concatenated). Not cleared by flush.
- RESET_DATA, 1: 1 = data registers reset to 0; 0 = data registers have no reset (area saving).

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous flush; discards all entries.
- in_valid, input, 1: upstream has an entry.
- in_ready, output, 1: stage can accept; registered.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: head entry present.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: head control; forced to 0 when out_valid=0.
- out_data, output, DATA_W: head data; undefined-but-stable when out_valid=0.
- occupancy, output, 2: entry count, 0..2.
- stall_cycles, output, 32: see Optional Feature.
- bubble_cycles, output, 32: see Optional Feature.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (head) and skid register, each with a valid bit.
- State machine: EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main and skid valid).
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in.
    - in_fire & !out_fire -> TWO, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - neither -> hold.
  - TWO:
    - out_fire -> ONE, main<=skid.
    - otherwise hold.
    - in_fire cannot occur because in_ready=0.
- in_ready = (state != TWO), taken from a register. The new value becomes visible in the cycle after the state changes.
- Latency:
  - In EMPTY, an entry accepted in cycle N is presented at out_* in cycle N+1.
  - Throughput is 1 entry/cycle while out_ready=1.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush or rst.
- Flush:
  - Highest synchronous priority. Next state is EMPTY, both valid bits are cleared and stored ctrl fields are zeroed.
  - in_ready=1 in the next cycle.
  - An in_fire in the flush cycle is discarded. An out_fire in the flush cycle still counts as consumed downstream.
  - Data registers hold their value.
- Reset:
  - Asynchronous; takes effect immediately, including mid-transfer.
  - After reset: state EMPTY, out_valid=0, out_ctrl=0, in_ready=1, occupancy=0, counters=0.
  - out_data=0 when RESET_DATA=1.
- out_ctrl gating is combinational from the main valid bit, so a non-valid head always reads as a NOP.
- in_ctrl and in_data are sampled only on in_fire. X values on them are permitted when in_valid=0.
- out_* must remain stable while out_valid=1 & out_ready=0.

Optional Feature:
- Macro: PIPELINE_STAGE_STATS_EN.
- When defined:
  - stall_cycles increments each cycle with out_valid & !out_ready.
  - bubble_cycles increments each cycle with !out_valid.
  - Both counters are 32-bit and saturate at 32'hFFFF_FFFF.
  - Both are cleared by rst only; flush does not clear them.
- When undefined: no counter logic; stall_cycles and bubble_cycles are tied to 32'h0.

Test Plan:
1. Reset-mid-transfer: load ctrl=4'hA, data=1 and hold out_ready=0, then assert rst asynchronously mid-cycle -> out_valid, out_ctrl and occupancy drop to 0 immediately, and in_ready=1.
2. Streaming: out_ready=1, push data 1..8 back-to-back -> out_data reads 1..8 in consecutive cycles starting 1 cycle after the first push, and occupancy stays 1.
3. Back-pressure: push A=0x11, B=0x22 with out_ready=0 -> occupancy=2 and in_ready=0 in the following cycle. Then release out_ready -> outputs A then B in order, and in_ready returns to 1.
4. Simultaneous push/pop in ONE with ctrl=4'h3, data=0x55 -> state stays ONE and out_data=0x55 in the next cycle.
5. Flush while TWO, with in_valid=1 in the flush cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and the input entry is never emitted.
6. Stats (with PIPELINE_STAGE_STATS_EN): 5 cycles out_valid=1 & out_ready=0, then 3 cycles empty -> stall_cycles=5 and bubble_cycles=3. Without the macro, both read 0.
